// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for the shared data memory port.
// Optional alignment checking is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_arbiter #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [1:0]  ls_size,
    input  logic        ls_sign,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        if_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        is_ls_q, is_ls_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        ls_ready_q, ls_ready_d;
    logic        if_err_q, if_err_d;
    logic        ls_err_q, ls_err_d;

    logic        grant_if;
    logic        access_err;
    logic        busy;

    // LS wins unless IF has been passed over STARVE_LIMIT times in a row.
    assign grant_if = if_req && (!ls_req || (starve_cnt_q == STARVE_MAX));

    always_comb begin
        access_err = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (grant_if) begin
            access_err = (if_addr[1:0] != 2'b00);
        end else begin
            case (ls_size)
                2'b00:   access_err = 1'b1;
                2'b10:   access_err = ls_addr[0];
                2'b11:   access_err = (ls_addr[1:0] != 2'b00);
                default: access_err = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        is_ls_d      = is_ls_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        sign_d       = sign_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_ready_d   = 1'b0;
        ls_ready_d   = 1'b0;
        if_err_d     = 1'b0;
        ls_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    is_ls_d    = !grant_if;
                    we_d       = grant_if ? 1'b0 : ls_we;
                    addr_d     = grant_if ? if_addr : ls_addr;
                    wdata_d    = grant_if ? 32'd0 : ls_wdata;
                    size_d     = grant_if ? 2'b11 : ls_size;
                    sign_d     = grant_if ? 1'b0 : ls_sign;
                    wait_cnt_d = WAIT_INIT;

                    if (grant_if) begin
                        starve_cnt_d = 8'd0;
                    end else if (if_req && (starve_cnt_q != 8'hFF)) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end

                    // Errored accesses never touch memory and complete on the next cycle.
                    if (access_err) begin
                        state_d    = DONE;
                        if_ready_d = grant_if;
                        ls_ready_d = !grant_if;
                        if_err_d   = grant_if;
                        ls_err_d   = !grant_if;
                        if (grant_if) begin
                            if_rdata_d = 32'd0;
                        end else begin
                            ls_rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = DONE;
                    if_ready_d = !is_ls_q;
                    ls_ready_d = is_ls_q;
                    if (!we_q) begin
                        if (is_ls_q) begin
                            ls_rdata_d = mem_dout;
                        end else begin
                            if_rdata_d = mem_dout;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_ls_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            wait_cnt_q   <= 4'd0;
            starve_cnt_q <= 8'd0;
            if_rdata_q   <= 32'd0;
            ls_rdata_q   <= 32'd0;
            if_ready_q   <= 1'b0;
            ls_ready_q   <= 1'b0;
            if_err_q     <= 1'b0;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_ls_q      <= is_ls_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            if_ready_q   <= if_ready_d;
            ls_ready_q   <= ls_ready_d;
            if_err_q     <= if_err_d;
            ls_err_q     <= ls_err_d;
        end
    end

    // Memory controls are decoded from registered state; rst squashes a pending store strobe.
    assign busy      = (state_q == BUSY);
    assign mem_read  = busy && !we_q;
    assign mem_write = busy && we_q && (wait_cnt_q == 4'd0) && !rst;
    assign mem_addr  = busy ? addr_q : 32'd0;
    assign mem_din   = busy ? wdata_q : 32'd0;
    assign mem_size  = busy ? size_q : 2'b00;
    assign mem_sign  = busy ? sign_q : 1'b0;

    assign if_ready = if_ready_q;
    assign ls_ready = ls_ready_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign if_err   = if_err_q;
    assign ls_err   = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-addressable memory behind the port plus a transaction-level
// reference of grant order, timing and data. Honours MEM_ARB_ALIGN_CHECK_EN if defined.
module tb_mem_arbiter;

   localparam int LAT   = 3;
   localparam int LIMIT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [1:0]  ls_size;
   logic        ls_sign;
   logic        ls_ready;
   logic [31:0] ls_rdata;
   logic        ls_err;
   logic        if_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  mem_size;
   logic        mem_sign;
   logic [31:0] mem_dout;

   logic [7:0]  mem    [0:8191];
   logic [7:0]  refMem [0:8191];
   logic        syncMem;

   int total = 0;
   int bad   = 0;

   // Pending requests as seen by the requesters, plus the expected held read data.
   logic        ifPend, lsPend, lsWe, lsSignV;
   logic [31:0] ifAddrV, lsAddrV, lsWdataV;
   logic [1:0]  lsSizeV;
   int          starve;
   int          regenMode;
   logic [31:0] expIfRdata, expLsRdata;
   logic [5:0]  grantLog;

   mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_size(ls_size), .ls_sign(ls_sign), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
      .ls_err(ls_err), .if_err(if_err),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write), .mem_read(mem_read),
      .mem_size(mem_size), .mem_sign(mem_sign), .mem_dout(mem_dout)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] sz, input logic sg);
      case (sz)
         2'b01:   return sg ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
         2'b10:   return sg ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic int sizeBytes(input logic [1:0] sz);
      case (sz)
         2'b01:   return 1;
         2'b10:   return 2;
         default: return 4;
      endcase
   endfunction

   // Combinational read side of the memory: little-endian bytes, extended by size/sign.
   logic [12:0] envBase;
   logic [31:0] envRaw;
   assign envBase  = mem_addr[12:0];
   assign envRaw   = {mem[envBase + 13'd3], mem[envBase + 13'd2], mem[envBase + 13'd1], mem[envBase]};
   assign mem_dout = extendLoad(envRaw, mem_size, mem_sign);

   // Write side of the memory; syncMem copies the preloaded image in at start-up.
   always @(posedge clk) begin
      if (syncMem) begin
         for (int i = 0; i < 8192; i++) mem[i] <= refMem[i];
      end else if (mem_write) begin
         for (int k = 0; k < sizeBytes(mem_size); k++)
            mem[(int'(mem_addr[12:0]) + k) % 8192] <= mem_din[8*k +: 8];
      end
   end

   function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      logic [12:0] b;
      b = a[12:0];
      return extendLoad({refMem[b + 13'd3], refMem[b + 13'd2], refMem[b + 13'd1], refMem[b]}, sz, sg);
   endfunction

   task automatic refStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      for (int k = 0; k < sizeBytes(sz); k++)
         refMem[(int'(a[12:0]) + k) % 8192] = d[8*k +: 8];
   endtask

   function automatic logic predictErr(input logic isIf, input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (isIf) return a[1:0] != 2'b00;
      case (sz)
         2'b00:   return 1'b1;
         2'b10:   return a[0];
         2'b11:   return a[1:0] != 2'b00;
         default: return 1'b0;
      endcase
`else
      return isIf & (a[1:0] == 2'b11) & (sz == 2'b00) & 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic genIf();
      ifPend  = 1'b1;
      ifAddrV = {26'd0, 4'($urandom_range(15)), 2'b00};
      if ($urandom_range(7) == 0) ifAddrV = 32'($urandom_range(63));
   endtask

   task automatic genLs();
      lsPend   = 1'b1;
      lsWe     = 1'($urandom_range(1));
      lsSizeV  = 2'($urandom_range(3, 1));
      lsAddrV  = 32'($urandom_range(63));
      lsWdataV = $urandom;
      lsSignV  = 1'($urandom_range(1));
      if ($urandom_range(7) != 0) begin
         if (lsSizeV == 2'b10) lsAddrV[0] = 1'b0;
         if (lsSizeV == 2'b11) lsAddrV[1:0] = 2'b00;
      end
   endtask

   task automatic driveInputs();
      if_req   = ifPend;
      if_addr  = ifAddrV;
      ls_req   = lsPend;
      ls_we    = lsWe;
      ls_addr  = lsAddrV;
      ls_wdata = lsWdataV;
      ls_size  = lsSizeV;
      ls_sign  = lsSignV;
   endtask

   // One arbitration round, entered and left at the falling edge of an IDLE cycle.
   task automatic applyStimulus(input bit allowNew);
      logic        winIf, we, sg, err;
      logic [31:0] addr, wdata, expData;
      logic [1:0]  sz;
      if (allowNew) begin
         if (!ifPend && $urandom_range(99) < 50) genIf();
         if (!lsPend && $urandom_range(99) < 60) genLs();
      end
      checkOutput("idleRead", {31'd0, mem_read}, 32'd0);
      checkOutput("idleWrite", {31'd0, mem_write}, 32'd0);
      checkOutput("idleAddr", mem_addr, 32'd0);
      checkOutput("idleReady", {30'd0, if_ready, ls_ready}, 32'd0);
      driveInputs();
      if (!ifPend && !lsPend) begin
         @(negedge clk);
         return;
      end

      winIf    = ifPend && (!lsPend || starve == LIMIT);
      grantLog = {grantLog[4:0], winIf};
      if (winIf) starve = 0;
      else if (ifPend && starve < 255) starve++;

      we    = winIf ? 1'b0 : lsWe;
      addr  = winIf ? ifAddrV : lsAddrV;
      wdata = lsWdataV;
      sz    = winIf ? 2'b11 : lsSizeV;
      sg    = winIf ? 1'b0 : lsSignV;
      err   = predictErr(winIf, addr, sz);
      expData = 32'd0;
      if (!err && !we) expData = refLoad(addr, sz, sg);
      if (!err && we) refStore(addr, wdata, sz);

      if (!err) begin
         for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput("busyRead", {31'd0, mem_read}, {31'd0, !we});
            checkOutput("busyWrite", {31'd0, mem_write}, {31'd0, we && (k == LAT)});
            checkOutput("busyAddr", mem_addr, addr);
            checkOutput("busySizeSign", {29'd0, mem_size, mem_sign}, {29'd0, sz, sg});
            if (we) checkOutput("busyDin", mem_din, wdata);
            checkOutput("busyReady", {30'd0, if_ready, ls_ready}, 32'd0);
         end
      end

      @(negedge clk);
      if (winIf) expIfRdata = expData;
      else if (err || !we) expLsRdata = expData;
      checkOutput("doneReady", {30'd0, if_ready, ls_ready}, {30'd0, winIf, !winIf});
      checkOutput("doneErr", {30'd0, if_err, ls_err}, {30'd0, winIf && err, !winIf && err});
      checkOutput("ifRdata", if_rdata, expIfRdata);
      checkOutput("lsRdata", ls_rdata, expLsRdata);
      checkOutput("doneMemCtl", {30'd0, mem_read, mem_write}, 32'd0);

      if (winIf) begin
         ifPend = 1'b0;
         if (regenMode == 1 || (regenMode == 0 && $urandom_range(1) == 1)) genIf();
      end else begin
         lsPend = 1'b0;
         if (regenMode == 1 || (regenMode == 0 && $urandom_range(1) == 1)) genLs();
      end
      driveInputs();
      @(negedge clk);
   endtask

   // Main sequence: reset, directed scenarios, random traffic, final memory image.
   initial begin
      int diffCount;
      ifPend = 0; lsPend = 0; lsWe = 0; lsSignV = 0;
      ifAddrV = 0; lsAddrV = 0; lsWdataV = 0; lsSizeV = 2'b11;
      starve = 0; regenMode = 2; expIfRdata = 0; expLsRdata = 0; grantLog = 0;
      for (int i = 0; i < 8192; i++) refMem[i] = 8'($urandom);
      refMem[32'h40] = 8'h44; refMem[32'h41] = 8'h33; refMem[32'h42] = 8'h22; refMem[32'h43] = 8'h11;
      driveInputs();
      rst = 1'b1;
      syncMem = 1'b1;
      @(negedge clk);
      syncMem = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstReady", {30'd0, if_ready, ls_ready}, 32'd0);
      checkOutput("rstErr", {30'd0, if_err, ls_err}, 32'd0);
      checkOutput("rstRdata", if_rdata | ls_rdata, 32'd0);
      checkOutput("rstMemCtl", {28'd0, mem_read, mem_write, mem_sign, |mem_size}, 32'd0);
      checkOutput("rstMemBus", mem_addr | mem_din, 32'd0);
      rst = 1'b0;

      lsPend = 1; lsWe = 0; lsAddrV = 32'h40; lsSizeV = 2'b11; lsSignV = 0;
      applyStimulus(0);
      checkOutput("wordLoad", ls_rdata, 32'h11223344);

      lsPend = 1; lsWe = 1; lsAddrV = 32'h10; lsWdataV = 32'h000000F0; lsSizeV = 2'b01;
      applyStimulus(0);
      lsPend = 1; lsWe = 0; lsSignV = 1;
      applyStimulus(0);
      checkOutput("signedByte", ls_rdata, 32'hFFFFFFF0);

      regenMode = 1;
      genIf(); genLs();
      repeat (6) applyStimulus(0);
      checkOutput("starveOrder", {26'd0, grantLog}, {26'd0, 6'b001001});
      regenMode = 2;
      repeat (2) applyStimulus(0);

      ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'hDEADBEEF; ls_size = 2'b11; ls_sign = 0;
      repeat (LAT) @(negedge clk);
      checkOutput("rstPreWrite", {31'd0, mem_write}, 32'd1);
      rst = 1'b1;
      ls_req = 1'b0;
      #1;
      checkOutput("rstGateWrite", {31'd0, mem_write}, 32'd0);
      @(negedge clk);
      checkOutput("rstAbortReady", {30'd0, if_ready, ls_ready}, 32'd0);
      checkOutput("rstAbortBus", mem_addr | mem_din | if_rdata | ls_rdata, 32'd0);
      checkOutput("rstAbortCtl", {29'd0, mem_read, mem_write, mem_sign}, 32'd0);
      rst = 1'b0;
      starve = 0; expIfRdata = 0; expLsRdata = 0; ifPend = 0; lsPend = 0;
      driveInputs();
      checkOutput("rstMemKept", {mem[35], mem[34], mem[33], mem[32]}, refLoad(32'h20, 2'b11, 1'b0));

      lsPend = 1; lsWe = 0; lsAddrV = 32'h22; lsSizeV = 2'b11; lsSignV = 0;
      applyStimulus(0);

      for (int i = 0; i < 3; i++) begin
         ifPend = 1; ifAddrV = 32'(4 * i);
         applyStimulus(0);
      end

      regenMode = 0;
      repeat (300) applyStimulus(1);
      regenMode = 2;
      repeat (2) applyStimulus(0);

      diffCount = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== refMem[i]) diffCount++;
      checkOutput("memImage", 32'(diffCount), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
